// File: rtl/seq_stage_execute_if.sv
// Handshake and payload bundle for the execute stage: upstream operation in, write-back bundle out.
interface seq_stage_execute_if #(
   parameter int unsigned ADDRESS_SIZE = 10,
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned OP_WIDTH     = 4
);
   logic                    i_valid;
   logic                    o_ready;
   logic [OP_WIDTH-1:0]     i_op;
   logic [DATA_SIZE-1:0]    i_operand1;
   logic [DATA_SIZE-1:0]    i_operand2;
   logic [5:0]              i_value;
   logic [7:0]              i_constant;
   logic [5:0]              i_offset;
   logic [2:0]              i_cond;
   logic [ADDRESS_SIZE-1:0] i_program_counter;
   logic [2:0]              i_destination;
   logic                    i_kill;
   logic                    o_valid;
   logic                    i_ready;
   logic [DATA_SIZE-1:0]    o_result;
   logic [2:0]              o_destination;
   logic                    o_register_file_write;
   logic [ADDRESS_SIZE-1:0] o_program_counter;
   logic                    o_program_counter_load;
   logic                    o_flush;
   logic                    o_busy;

   // Surrounding pipeline side: drives operations in, consumes the result bundle.
   modport master (
      output i_valid, i_op, i_operand1, i_operand2, i_value, i_constant, i_offset,
             i_cond, i_program_counter, i_destination, i_kill, i_ready,
      input  o_ready, o_valid, o_result, o_destination, o_register_file_write,
             o_program_counter, o_program_counter_load, o_flush, o_busy
   );

   modport slave (
      input  i_valid, i_op, i_operand1, i_operand2, i_value, i_constant, i_offset,
             i_cond, i_program_counter, i_destination, i_kill, i_ready,
      output o_ready, o_valid, o_result, o_destination, o_register_file_write,
             o_program_counter, o_program_counter_load, o_flush, o_busy
   );
endinterface

// File: rtl/seq_stage_execute.sv
// Registered valid/ready execute stage: ALU, shifts, LOADC, relative jumps, optional iterative MUL.
// Define SEQ_EXECUTE_MUL_EN to build the radix-2 multiplier; otherwise opcode 13 executes as NOP.
module seq_stage_execute #(
   parameter int unsigned ADDRESS_SIZE = 10,
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned OP_WIDTH     = 4
) (
   input logic               i_clk,
   input logic               i_rst_n,
   seq_stage_execute_if.slave bus
);

   localparam logic [OP_WIDTH-1:0] OP_NOP     = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_ADD     = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SUB     = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_AND     = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_OR      = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_XOR     = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_NAND    = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_NOR     = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_NXOR    = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] OP_SHIFTR  = OP_WIDTH'(9);
   localparam logic [OP_WIDTH-1:0] OP_SHIFTRA = OP_WIDTH'(10);
   localparam logic [OP_WIDTH-1:0] OP_SHIFTL  = OP_WIDTH'(11);
   localparam logic [OP_WIDTH-1:0] OP_LOADC   = OP_WIDTH'(12);
   localparam logic [OP_WIDTH-1:0] OP_MUL     = OP_WIDTH'(13);
   localparam logic [OP_WIDTH-1:0] OP_JMPR    = OP_WIDTH'(14);
   localparam logic [OP_WIDTH-1:0] OP_JMPRC   = OP_WIDTH'(15);

`ifdef SEQ_EXECUTE_MUL_EN
   localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
`else
   typedef enum logic [0:0] {S_IDLE = 1'b0} state_t;
`endif

   state_t                  state_q, state_d;
   logic                    rdy_q;
   logic                    valid_q, valid_d;
   logic [DATA_SIZE-1:0]    res_q, res_d;
   logic [2:0]              dst_q, dst_d;
   logic                    wr_q, wr_d;
   logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
   logic                    pcl_q, pcl_d;
   logic                    fl_q, fl_d;

`ifdef SEQ_EXECUTE_MUL_EN
   logic [DATA_SIZE-1:0]    mcand_q, mcand_d;
   logic [DATA_SIZE-1:0]    mplier_q, mplier_d;
   logic [DATA_SIZE-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [2:0]              mdst_q, mdst_d;
`endif

   logic                    ready_c;
   logic                    accept_c;
   logic                    xfer_c;
   logic [DATA_SIZE-1:0]    alu_res_c;
   logic                    alu_wr_c;
   logic                    jmp_take_c;
   logic                    cond_ok_c;
   logic                    shift_big_c;
   logic [ADDRESS_SIZE-1:0] jmp_target_c;

   // rdy_q keeps the stage closed while reset is held and opens it on the first edge after release.
   assign ready_c  = rdy_q && (state_q == S_IDLE) && (!valid_q || bus.i_ready) && !bus.i_kill;
   assign accept_c = bus.i_valid && ready_c;
   assign xfer_c   = valid_q && bus.i_ready;

   // Single-cycle datapath for every operation except the iterative multiply.
   always_comb begin
      alu_res_c    = '0;
      alu_wr_c     = 1'b1;
      jmp_take_c   = 1'b0;
      shift_big_c  = 32'(bus.i_value) >= DATA_SIZE;
      jmp_target_c = bus.i_program_counter + ADDRESS_SIZE'($signed(bus.i_offset));
      case (bus.i_cond)
         3'd0:    cond_ok_c = bus.i_operand2[DATA_SIZE-1];
         3'd1:    cond_ok_c = !bus.i_operand2[DATA_SIZE-1];
         3'd2:    cond_ok_c = (bus.i_operand2 == '0);
         3'd3:    cond_ok_c = (bus.i_operand2 != '0);
         default: cond_ok_c = 1'b0;
      endcase
      case (bus.i_op)
         OP_NOP:     alu_wr_c = 1'b0;
         OP_ADD:     alu_res_c = bus.i_operand1 + bus.i_operand2;
         OP_SUB:     alu_res_c = bus.i_operand1 - bus.i_operand2;
         OP_AND:     alu_res_c = bus.i_operand1 & bus.i_operand2;
         OP_OR:      alu_res_c = bus.i_operand1 | bus.i_operand2;
         OP_XOR:     alu_res_c = bus.i_operand1 ^ bus.i_operand2;
         OP_NAND:    alu_res_c = ~(bus.i_operand1 & bus.i_operand2);
         OP_NOR:     alu_res_c = ~(bus.i_operand1 | bus.i_operand2);
         OP_NXOR:    alu_res_c = ~(bus.i_operand1 ^ bus.i_operand2);
         OP_SHIFTR:  alu_res_c = shift_big_c ? '0 : (bus.i_operand2 >> bus.i_value);
         OP_SHIFTRA: alu_res_c = shift_big_c ? {DATA_SIZE{bus.i_operand2[DATA_SIZE-1]}}
                                             : $unsigned($signed(bus.i_operand2) >>> bus.i_value);
         OP_SHIFTL:  alu_res_c = shift_big_c ? '0 : (bus.i_operand2 << bus.i_value);
         OP_LOADC:   alu_res_c = {bus.i_operand2[DATA_SIZE-1:8], bus.i_constant};
`ifdef SEQ_EXECUTE_MUL_EN
         OP_MUL:     alu_wr_c = 1'b1;
`else
         OP_MUL:     alu_wr_c = 1'b0;
`endif
         OP_JMPR: begin
            alu_wr_c   = 1'b0;
            jmp_take_c = 1'b1;
         end
         OP_JMPRC: begin
            alu_wr_c   = 1'b0;
            jmp_take_c = cond_ok_c;
         end
         default:    alu_wr_c = 1'b0;
      endcase
   end

   // Next-state and next-output logic; kill overrides everything at the end.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      res_d    = res_q;
      dst_d    = dst_q;
      wr_d     = wr_q;
      pc_d     = pc_q;
      pcl_d    = pcl_q;
      fl_d     = fl_q;
`ifdef SEQ_EXECUTE_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mdst_d   = mdst_q;
`endif
      if (xfer_c) begin
         valid_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
`ifdef SEQ_EXECUTE_MUL_EN
               if (bus.i_op == OP_MUL) begin
                  mcand_d  = bus.i_operand1;
                  mplier_d = bus.i_operand2;
                  acc_d    = '0;
                  cnt_d    = CNT_W'(DATA_SIZE);
                  mdst_d   = bus.i_destination;
                  state_d  = S_MUL;
               end else begin
`else
               begin
`endif
                  valid_d = 1'b1;
                  res_d   = alu_res_c;
                  dst_d   = bus.i_destination;
                  wr_d    = alu_wr_c;
                  pc_d    = jmp_take_c ? jmp_target_c : '0;
                  pcl_d   = jmp_take_c;
                  fl_d    = jmp_take_c;
               end
            end
         end
`ifdef SEQ_EXECUTE_MUL_EN
         S_MUL: begin
            if (cnt_q != '0) begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - CNT_W'(1);
            end else if (!valid_q || bus.i_ready) begin
               // Product lands only once the output register is free.
               valid_d = 1'b1;
               res_d   = acc_q;
               dst_d   = mdst_q;
               wr_d    = 1'b1;
               pc_d    = '0;
               pcl_d   = 1'b0;
               fl_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (bus.i_kill) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         rdy_q    <= 1'b0;
         valid_q  <= 1'b0;
         res_q    <= '0;
         dst_q    <= '0;
         wr_q     <= 1'b0;
         pc_q     <= '0;
         pcl_q    <= 1'b0;
         fl_q     <= 1'b0;
`ifdef SEQ_EXECUTE_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mdst_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rdy_q    <= 1'b1;
         valid_q  <= valid_d;
         res_q    <= res_d;
         dst_q    <= dst_d;
         wr_q     <= wr_d;
         pc_q     <= pc_d;
         pcl_q    <= pcl_d;
         fl_q     <= fl_d;
`ifdef SEQ_EXECUTE_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mdst_q   <= mdst_d;
`endif
      end
   end

   assign bus.o_ready                = ready_c;
   assign bus.o_valid                = valid_q;
   assign bus.o_result               = res_q;
   assign bus.o_destination          = dst_q;
   assign bus.o_register_file_write  = wr_q;
   assign bus.o_program_counter      = pc_q;
   assign bus.o_program_counter_load = pcl_q;
   assign bus.o_flush                = fl_q;
`ifdef SEQ_EXECUTE_MUL_EN
   assign bus.o_busy                 = (state_q == S_MUL);
`else
   assign bus.o_busy                 = 1'b0;
`endif

endmodule

// File: doc/seq_stage_execute.md
Name: seq_stage_execute

Overview:
Registered, handshaked execute stage for the pipelined core.
- Replaces the purely combinational execute path with a valid/ready stage.
- Adds an iterative multi-cycle multiplier and a kill input for branch-flush recovery.
- Sits between the read/decode stage and the write-back stage.
- Carries ALU, barrel-shift, LOADC, MUL and relative-jump operations; memory operations bypass it.

Parameters:
- ADDRESS_SIZE, 10, width of program counter values.
- DATA_SIZE, 32, operand/result width; must be >= 8.
- OP_WIDTH, 4, opcode width; must stay 4 for the fixed encoding below.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream operation valid.
- o_ready  out  1  stage can accept an operation this cycle.
- i_op  in  OP_WIDTH  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NAND, 7 NOR, 8 NXOR, 9 SHIFTR, 10 SHIFTRA, 11 SHIFTL, 12 LOADC, 13 MUL, 14 JMPR, 15 JMPRcond.
- i_operand1  in  DATA_SIZE  signed operand 1.
- i_operand2  in  DATA_SIZE  signed operand 2 (shift source, LOADC base, condition register).
- i_value  in  6  shift amount.
- i_constant  in  8  LOADC constant.
- i_offset  in  6  signed jump offset.
- i_cond  in  3  condition: 0 N, 1 NN, 2 Z, 3 NZ; 4-7 never taken.
- i_program_counter  in  ADDRESS_SIZE  PC of the operation.
- i_destination  in  3  destination register index.
- i_kill  in  1  flush: discard in-flight and held operations.
- o_valid  out  1  output bundle valid.
- i_ready  in  1  downstream accepts the bundle.
- o_result  out  DATA_SIZE  result.
- o_destination  out  3  registered i_destination.
- o_register_file_write  out  1  result must be written to the register file.
- o_program_counter  out  ADDRESS_SIZE  jump target.
- o_program_counter_load  out  1  jump taken.
- o_flush  out  1  flush younger stages.
- o_busy  out  1  multiplier iterating.

Behaviour:
- Reset (asynchronous, i_rst_n=0): all outputs and internal registers go to 0; state goes to IDLE. o_ready is 0 while reset is asserted.
- Handshakes:
  - Accept occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - o_ready = (state==IDLE) && (!o_valid || i_ready) && !i_kill.
- States:
  - IDLE: on accepting a non-MUL op, the output bundle is registered on the same edge; o_valid=1 next cycle (latency 1). On accepting MUL, latch the operands, clear the accumulator, load counter = DATA_SIZE, go to MUL.
  - MUL: radix-2 shift-add, one bit per cycle; o_busy=1. When the counter reaches 0, register the product, set o_valid, go to IDLE. MUL latency = DATA_SIZE+1 cycles from accept to o_valid.
- Output hold: while o_valid && !i_ready, every output is held stable. MUL cannot complete into an occupied output; it stalls in MUL with the counter at 0 until the output frees.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_SIZE.
  - MUL result is the low DATA_SIZE bits of the product (identical for signed and unsigned).
  - SHIFTR is logical, SHIFTRA is arithmetic on operand2, SHIFTL shifts operand2 left.
  - Shift amounts >= DATA_SIZE give 0 (SHIFTR/SHIFTL) or sign fill (SHIFTRA).
  - LOADC result = {operand2[DATA_SIZE-1:8], constant}.
- Write flag: o_register_file_write=1 for ops 1-13; 0 for NOP and jumps.
- Jumps:
  - Target = PC + sign-extended offset, truncated to ADDRESS_SIZE (wraps).
  - JMPR is always taken.
  - JMPRcond is taken per i_cond on operand2: N = MSB=1, NN = MSB=0, Z = ==0, NZ = !=0.
  - When taken, o_program_counter_load=1 and o_flush=1 for that bundle. When not taken, both are 0 and o_program_counter=0.
  - These flags are meaningful only while o_valid=1.
- Kill:
  - i_kill=1 clears o_valid next edge, aborts MUL to IDLE, and blocks accept in the same cycle (kill wins over a simultaneous accept).
  - A bundle already transferring in the kill cycle counts as delivered.
- Reset mid-MUL returns to IDLE with no output.

Optional Feature:
- Macro: SEQ_EXECUTE_MUL_EN.
- Defined: MUL is implemented as described above.
- Undefined: no multiplier logic is built and the MUL state is absent. Opcode 13 behaves as NOP (latency 1, o_register_file_write=0, o_result=0), and o_busy is tied 0.

Test Plan:
- Reset: assert i_rst_n=0 mid-operation -> all outputs 0 immediately; after release, o_ready=1 next cycle.
- ADD back-to-back with i_ready=1: operands 0x7FFFFFFF + 1, then 5 - 7 -> o_result 0x80000000, then 0xFFFFFFFE, one per cycle, o_register_file_write=1.
- Backpressure: hold i_ready=0 with o_valid=1 -> o_ready=0 and the bundle stays stable 5 cycles; raise i_ready -> transfer, next op accepted the same cycle.
- MUL: 0xFFFFFFFF*3 -> o_valid exactly 33 cycles after accept, o_result 0xFFFFFFFD, o_busy high throughout, o_ready=0. Repeat with SEQ_EXECUTE_MUL_EN undefined -> NOP behaviour.
- JMPRcond: PC=3, offset=-5, cond Z, operand2=0 -> o_program_counter=1022, load=1, flush=1. Same with operand2=1 -> load=0, flush=0.
- Kill: assert i_kill at cycle 10 of MUL, concurrent with i_valid -> no o_valid, state IDLE, nothing accepted that cycle.
